// File: rtl/ins_fetch_queue_if.sv
// Fetch-unit bundle: redirect input, instruction-memory request/response
// channel and the decode-side valid/ready queue head.
interface ins_fetch_queue_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ins_valid;
    logic [31:0] ins_out;
    logic [31:0] ins_pc;
    logic        ins_ready;

    // Fetch unit side
    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req, imem_addr,
        input  imem_ready, imem_rvalid, imem_rdata,
        output ins_valid, ins_out, ins_pc,
        input  ins_ready
    );

    // Environment side (memory, decode, branch unit)
    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req, imem_addr,
        output imem_ready, imem_rvalid, imem_rdata,
        input  ins_valid, ins_out, ins_pc,
        output ins_ready
    );
endinterface

// File: rtl/ins_fetch_queue.sv
// Instruction fetch unit: owns the PC, keeps at most one memory request in
// flight, and buffers returned {pc, instruction} pairs in a small FIFO for
// decode. A redirect flushes the FIFO and drops any response still in flight.
module ins_fetch_queue #(
    parameter logic [31:0] PC_START = 32'h0040_0020,
    parameter logic [31:0] PC_INC   = 32'h0000_0004,
    parameter int          QDEPTH   = 4
) (
    input  logic             clk,
    input  logic             reset,
    ins_fetch_queue_if.master bus
);
    localparam int AW = $clog2(QDEPTH);
    localparam logic [AW:0] QD = (AW+1)'(QDEPTH);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [31:0]    r_pc;
    logic [31:0]    r_req_pc;
    logic [AW:0]    r_cnt;
    logic [AW-1:0]  r_rd;
    logic [AW-1:0]  r_wr;
    logic [31:0]    r_q_pc  [QDEPTH];
    logic [31:0]    r_q_ins [QDEPTH];

    logic           w_req;
    logic           w_issue;
    logic           w_push;
    logic           w_pop;
    logic           w_valid;
    logic [31:0]    w_redir_pc;

    // Request only from REQ with a free slot guaranteed; a redirect cycle
    // never issues because the PC is about to change. Held low in reset.
    assign w_req      = !reset && (r_state == S_REQ) && !bus.redirect_valid && (r_cnt < QD);
    assign w_issue    = w_req && bus.imem_ready;
    // A response that lands in the redirect cycle is stale and not pushed.
    assign w_push     = (r_state == S_WAIT) && bus.imem_rvalid && !bus.redirect_valid;
    assign w_valid    = (r_cnt != '0);
    assign w_pop      = w_valid && bus.ins_ready;
    assign w_redir_pc = bus.redirect_pc & ~32'h3;

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = r_pc;
    assign bus.ins_valid = w_valid;
    assign bus.ins_out   = r_q_ins[r_rd];
    assign bus.ins_pc    = r_q_pc[r_rd];

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_REQ;
        else       r_state <= w_state_nxt;
    end

    // FSM next state: redirect turns an outstanding request into a drop
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_REQ: begin
                if (w_issue) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (bus.imem_rvalid)         w_state_nxt = S_REQ;
                else if (bus.redirect_valid) w_state_nxt = S_DROP;
            end
            S_DROP: begin
                if (bus.imem_rvalid) w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    // PC and the PC of the request currently in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc     <= PC_START;
            r_req_pc <= '0;
        end else if (bus.redirect_valid) begin
            r_pc     <= w_redir_pc;
        end else if (w_issue) begin
            r_pc     <= r_pc + PC_INC;
            r_req_pc <= r_pc;
        end
    end

    // Queue occupancy and pointers; redirect empties the queue
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_rd  <= '0;
            r_wr  <= '0;
        end else if (bus.redirect_valid) begin
            r_cnt <= '0;
            r_rd  <= '0;
            r_wr  <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Queue storage; cleared in reset so the head reads zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_pc[i]  <= '0;
                r_q_ins[i] <= '0;
            end
        end else if (w_push) begin
            r_q_pc[r_wr]  <= r_req_pc;
            r_q_ins[r_wr] <= bus.imem_rdata;
        end
    end
endmodule

// File: tb/tb_ins_fetch_queue.sv
// Directed bench for ins_fetch_queue: one record per clock cycle holding the
// inputs for that cycle and the outputs expected before the rising edge.
module tb_ins_fetch_queue;
    logic clk = 1'b0;
    logic reset;

    ins_fetch_queue_if bus();

    ins_fetch_queue dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        mrdy;
        logic        mrv;
        logic [31:0] mrd;
        logic        irdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic        chk_head;
        logic [31:0] e_pc;
        logic [31:0] e_out;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;
    int row    = 0;
    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic rv, logic [31:0] rpc, logic mrdy,
                                logic mrv, logic [31:0] mrd, logic irdy, logic e_req,
                                logic [31:0] e_addr, logic e_val, logic chk_head,
                                logic [31:0] e_pc, logic [31:0] e_out);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rpc = rpc; v.mrdy = mrdy; v.mrv = mrv;
        v.mrd = mrd; v.irdy = irdy; v.e_req = e_req; v.e_addr = e_addr;
        v.e_val = e_val; v.chk_head = chk_head; v.e_pc = e_pc; v.e_out = e_out;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, check before the rise
    task automatic apply(input vec_t v);
        @(negedge clk);
        reset              = v.rst;
        bus.redirect_valid = v.rv;
        bus.redirect_pc    = v.rpc;
        bus.imem_ready     = v.mrdy;
        bus.imem_rvalid    = v.mrv;
        bus.imem_rdata     = v.mrd;
        bus.ins_ready      = v.irdy;
        #2;
        chk("imem_req",  {31'd0, bus.imem_req},  {31'd0, v.e_req});
        chk("imem_addr", bus.imem_addr,          v.e_addr);
        chk("ins_valid", {31'd0, bus.ins_valid}, {31'd0, v.e_val});
        if (v.chk_head) begin
            chk("ins_pc",  bus.ins_pc,  v.e_pc);
            chk("ins_out", bus.ins_out, v.e_out);
        end
        row++;
    endtask

    initial begin
        reset = 1'b1;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
        bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0;
        bus.imem_rdata = '0;   bus.ins_ready = 1'b0;

        // Reset state
        tbl.push_back(mk(1,0,0, 1,0,0, 1,  0,32'h0040_0020, 0,1,32'h0,32'h0));
        // Sequential fetch, 1-cycle memory, decode always ready
        tbl.push_back(mk(0,0,0, 1,0,0,            1, 1,32'h0040_0020, 0,0,0,0));
        tbl.push_back(mk(0,0,0, 1,1,32'hA000_0000,1, 0,32'h0040_0024, 0,0,0,0));
        tbl.push_back(mk(0,0,0, 1,0,0,            1, 1,32'h0040_0024, 1,1,32'h0040_0020,32'hA000_0000));
        tbl.push_back(mk(0,0,0, 1,1,32'hA000_0001,1, 0,32'h0040_0028, 0,0,0,0));
        tbl.push_back(mk(0,0,0, 1,0,0,            1, 1,32'h0040_0028, 1,1,32'h0040_0024,32'hA000_0001));
        tbl.push_back(mk(0,0,0, 1,1,32'hA000_0002,1, 0,32'h0040_002C, 0,0,0,0));
        tbl.push_back(mk(0,0,0, 0,0,0,            1, 1,32'h0040_002C, 1,1,32'h0040_0028,32'hA000_0002));
        // Decode stalled: four pushes, then request held off while full
        tbl.push_back(mk(0,0,0, 1,0,0,            0, 1,32'h0040_002C, 0,0,0,0));
        tbl.push_back(mk(0,0,0, 1,1,32'hB000_0000,0, 0,32'h0040_0030, 0,0,0,0));
        tbl.push_back(mk(0,0,0, 1,0,0,            0, 1,32'h0040_0030, 1,1,32'h0040_002C,32'hB000_0000));
        tbl.push_back(mk(0,0,0, 1,1,32'hB000_0001,0, 0,32'h0040_0034, 1,1,32'h0040_002C,32'hB000_0000));
        tbl.push_back(mk(0,0,0, 1,0,0,            0, 1,32'h0040_0034, 1,1,32'h0040_002C,32'hB000_0000));
        tbl.push_back(mk(0,0,0, 1,1,32'hB000_0002,0, 0,32'h0040_0038, 1,1,32'h0040_002C,32'hB000_0000));
        tbl.push_back(mk(0,0,0, 1,0,0,            0, 1,32'h0040_0038, 1,1,32'h0040_002C,32'hB000_0000));
        tbl.push_back(mk(0,0,0, 1,1,32'hB000_0003,0, 0,32'h0040_003C, 1,1,32'h0040_002C,32'hB000_0000));
        tbl.push_back(mk(0,0,0, 1,0,0,            0, 0,32'h0040_003C, 1,1,32'h0040_002C,32'hB000_0000));
        tbl.push_back(mk(0,0,0, 1,0,0,            0, 0,32'h0040_003C, 1,1,32'h0040_002C,32'hB000_0000));
        // Decode resumes: in-order pops, requests resume below full
        tbl.push_back(mk(0,0,0, 1,0,0,            1, 0,32'h0040_003C, 1,1,32'h0040_002C,32'hB000_0000));
        tbl.push_back(mk(0,0,0, 1,0,0,            1, 1,32'h0040_003C, 1,1,32'h0040_0030,32'hB000_0001));
        tbl.push_back(mk(0,0,0, 1,1,32'hC000_0000,1, 0,32'h0040_0040, 1,1,32'h0040_0034,32'hB000_0002));
        tbl.push_back(mk(0,0,0, 1,0,0,            1, 1,32'h0040_0040, 1,1,32'h0040_0038,32'hB000_0003));
        tbl.push_back(mk(0,0,0, 1,1,32'hC000_0001,1, 0,32'h0040_0044, 1,1,32'h0040_003C,32'hC000_0000));
        tbl.push_back(mk(0,0,0, 0,0,0,            1, 1,32'h0040_0044, 1,1,32'h0040_0040,32'hC000_0001));
        tbl.push_back(mk(0,0,0, 0,0,0,            0, 1,32'h0040_0044, 0,0,0,0));

        foreach (tbl[i]) apply(tbl[i]);

        // Redirect while waiting; response arrives three cycles later and is dropped
        apply(mk(0,0,0,            1,0,0,            0, 1,32'h0040_0044, 0,0,0,0));
        apply(mk(0,1,32'h0040_1003,1,0,0,            0, 0,32'h0040_0048, 0,0,0,0));
        apply(mk(0,0,0,            1,0,0,            0, 0,32'h0040_1000, 0,0,0,0));
        apply(mk(0,0,0,            1,0,0,            0, 0,32'h0040_1000, 0,0,0,0));
        apply(mk(0,0,0,            1,1,32'hDEAD_BEEF,0, 0,32'h0040_1000, 0,0,0,0));
        apply(mk(0,0,0,            1,0,0,            0, 1,32'h0040_1000, 0,0,0,0));
        apply(mk(0,0,0,            0,1,32'h1111_1111,0, 0,32'h0040_1004, 0,0,0,0));
        apply(mk(0,0,0,            0,0,0,            1, 1,32'h0040_1004, 1,1,32'h0040_1000,32'h1111_1111));

        // Redirect in the same cycle as the response: no push
        apply(mk(0,0,0,            1,0,0,            0, 1,32'h0040_1004, 0,0,0,0));
        apply(mk(0,1,32'h0050_0000,1,1,32'hBAD0_BAD0,0, 0,32'h0040_1008, 0,0,0,0));
        apply(mk(0,0,0,            1,0,0,            0, 1,32'h0050_0000, 0,0,0,0));
        apply(mk(0,0,0,            0,1,32'h2222_2222,0, 0,32'h0050_0004, 0,0,0,0));
        apply(mk(0,0,0,            0,0,0,            1, 1,32'h0050_0004, 1,1,32'h0050_0000,32'h2222_2222));

        // PC wrap at the top of the address space, then reset mid-WAIT
        apply(mk(0,1,32'hFFFF_FFFF,0,0,0,            0, 0,32'h0050_0004, 0,0,0,0));
        apply(mk(0,0,0,            1,0,0,            0, 1,32'hFFFF_FFFC, 0,0,0,0));
        apply(mk(0,0,0,            1,0,0,            0, 0,32'h0000_0000, 0,0,0,0));
        apply(mk(1,0,0,            1,0,0,            0, 0,32'h0040_0020, 0,1,32'h0,32'h0));
        apply(mk(0,0,0,            0,0,0,            0, 1,32'h0040_0020, 0,0,0,0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
